// File: rtl/sram_bank_pkg.sv
// rtl/sram_bank_pkg.sv - shared memory-subsystem defines and sram_bank types
//
// Holds the access-convention macros used across the memory subsystem
// (widths, active-low enable, read/write polarity) and the clear
// sequencer state encodings, plus the package imported by sram_bank files.
`ifndef SRAM_BANK_DEFS
`define SRAM_BANK_DEFS
`define MEM_ADDR_WIDTH 10
`define DATA_WIDTH     32
`define Enable_        1'b0
`define Disable_       1'b1
`define Read           1'b1
`define Write          1'b0
`define SRAM_INIT      1'b0
`define SRAM_READY     1'b1
`endif

package sram_bank_pkg;

  typedef enum logic {
    ST_INIT  = `SRAM_INIT,
    ST_READY = `SRAM_READY
  } init_state_t;

  localparam int MIN_READ_LAT = 1;
  localparam int MAX_READ_LAT = 3;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int clamp_lat(input int lat);
    if (lat < MIN_READ_LAT) return MIN_READ_LAT;
    if (lat > MAX_READ_LAT) return MAX_READ_LAT;
    return lat;
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// rtl/sram_init_seq.sv - post-reset clear sequencer for sram_bank
//
// Sweeps every word address once after reset, raising busy until done.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset; restarts the sweep
//   busy  out  high while the sweep is running (decoded from state register)
//   addr  out  address being cleared this cycle
module sram_init_seq
  import sram_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr
);

  init_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == ST_INIT) begin
      cnt_next = cnt + ADDR_WIDTH'(1);
      // Last address cleared this cycle; counter wraps back to 0.
      if (cnt == '1) state_next = ST_READY;
    end
  end

  assign busy = (state == ST_INIT);
  assign addr = cnt;

endmodule

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - single-port synchronous SRAM bank with byte enables and registered read
//
// Optional feature macro: SRAM_INIT_EN (compiles in the post-reset clear sequencer).
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   cs_     in   chip select, active-low
//   rw_     in   1 = read, 0 = write
//   be      in   byte write enables (ignored on reads)
//   addr    in   word address
//   idata   in   write data
//   odata   out  registered read data, holds between reads
//   ovalid  out  one-cycle strobe per read result
//   busy    out  high while accesses are refused
module sram_bank
  import sram_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int BYTE_WIDTH = 8,
  parameter int READ_LAT   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cs_,
  input  logic                             rw_,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            idata,
  output logic [DATA_WIDTH-1:0]            odata,
  output logic                             ovalid,
  output logic                             busy
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LAT   = clamp_lat(READ_LAT);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic accept, rd_accept, wr_accept;
  assign accept    = (cs_ == `Enable_) && !busy;
  assign rd_accept = accept && (rw_ == `Read);
  assign wr_accept = accept && (rw_ == `Write);

  // Single write port, shared by host and (optionally) the clear sequencer.
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LANES-1:0]      wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

`ifdef SRAM_INIT_EN
  logic                  init_busy;
  logic [ADDR_WIDTH-1:0] init_addr;

  sram_init_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_init_seq (
    .clk  (clk),
    .rst  (rst),
    .busy (init_busy),
    .addr (init_addr)
  );

  assign busy = init_busy;

  always_comb begin
    wr_en   = wr_accept;
    wr_addr = addr;
    wr_be   = be;
    wr_data = idata;
    if (init_busy) begin
      wr_en   = 1'b1;
      wr_addr = init_addr;
      wr_be   = '1;
      wr_data = '0;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    wr_en   = wr_accept;
    wr_addr = addr;
    wr_be   = be;
    wr_data = idata;
  end
`endif

  // Array has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage 0 samples the array at the accept edge; odata is one more register
  // past the last stage, giving LAT edges from accept to result.
  for (genvar s = 0; s < LAT; s++) begin : g_rd
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;

    if (s == 0) begin : g_head
      assign in_valid = rd_accept;
      assign in_data  = mem[addr];
    end else begin : g_tail
      assign in_valid = g_rd[s-1].valid;
      assign in_data  = g_rd[s-1].data;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) valid <= 1'b0;
      else     valid <= in_valid;
    end

    always_ff @(posedge clk) begin
      if (in_valid) data <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odata  <= '0;
      ovalid <= 1'b0;
    end else begin
      ovalid <= g_rd[LAT-1].valid;
      if (g_rd[LAT-1].valid) odata <= g_rd[LAT-1].data;
    end
  end

endmodule

// File: doc/sram_bank.md
# sram_bank

Parametrised single-port synchronous SRAM bank for the processor's data and instruction memories. It adds per-byte write enables, a registered read path of configurable latency with a valid strobe, and an optional post-reset clear sequencer. It keeps the active-low chip-select/read-write access convention used by the rest of the memory subsystem.

## Interface

Parameters:
- ADDR_WIDTH, default `MEM_ADDR_WIDTH: word address bits; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, default `DATA_WIDTH: word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, default 8: bits per write-enable lane.
- READ_LAT, default 1: read latency in cycles, legal range 1..3.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs_  in  1  chip select, active-low (`Enable_).
- rw_  in  1  `Read (1) / `Write (0).
- be  in  DATA_WIDTH/BYTE_WIDTH  byte write enables, active-high; ignored on reads.
- addr  in  ADDR_WIDTH  word address.
- idata  in  DATA_WIDTH  write data.
- odata  out  DATA_WIDTH  read data, registered.
- ovalid  out  1  one-cycle pulse when odata carries a new read result.
- busy  out  1  high while the bank refuses accesses.

## Operation

- An access is accepted on a rising edge when cs_ = `Enable_ and busy = 0. When busy = 1, accesses are dropped silently: no write, no ovalid.
- Write (rw_ = `Write): for each lane i with be[i] = 1, mem[addr] lane i <= idata lane i. Lanes with be[i] = 0 keep their contents. be = 0 is a legal no-op.
- Read (rw_ = `Read): the array is sampled at the accept edge. The result moves through a READ_LAT-stage pipeline, each stage carrying data plus a valid bit.
  - odata updates only when the last stage is valid.
  - odata holds its value between reads.
- Back-to-back reads issue one per cycle. ovalid stays high for consecutive results.
- Write followed by a read of the same address on the next cycle returns the new data.
- Read and write cannot occur in the same cycle, because the bank is single-port.
- Reset values: odata = 0, ovalid = 0, all pipeline valid bits = 0. busy reflects the configuration (see below).
- Reset asserted mid-read flushes the pipeline. No ovalid is produced for in-flight reads. Array contents are not disturbed by reset itself.

## Timing

- Read accepted at edge N: odata and ovalid are valid after edge N+READ_LAT, with ovalid high for exactly that cycle.
- Write accepted at edge N: visible to a read accepted at edge N+1 or later.
- busy is registered. Accesses presented in the first cycle after busy falls are accepted.

## Configuration

Macro: SRAM_INIT_EN.

With SRAM_INIT_EN defined, a clear sequencer is compiled in. It has two states, INIT and READY:
- Reset forces INIT with an address counter of 0 and busy = 1.
- Each cycle in INIT, the sequencer writes 0 to all lanes of mem[counter], then increments the counter.
- After writing address 2^ADDR_WIDTH-1, the counter wraps and the sequencer moves to READY with busy = 0. The sweep takes exactly 2^ADDR_WIDTH cycles.
- Reset asserted mid-sweep restarts the sweep from address 0.
- Host accesses during INIT are ignored.

Without SRAM_INIT_EN, busy is tied to 0 and array contents after power-up are undefined.

## Structure

- The shared define header holds `MEM_ADDR_WIDTH, `DATA_WIDTH, `Enable_, `Disable_, `Read, `Write, plus new `SRAM_INIT and `SRAM_READY state encodings.
- One sub-module, sram_init_seq, contains the clear FSM and address counter. It drives the write port through a mux ahead of the array and is instantiated only under SRAM_INIT_EN.
- The read pipeline stays inline as a generate loop over READ_LAT.

## Test plan

- Reset, then READ_LAT = 2: write 0xDEADBEEF to address 5 with be = 4'b1111, then read address 5 -> odata = 0xDEADBEEF with an ovalid pulse 2 cycles after the read accept edge. odata = 0 and ovalid = 0 during reset.
- Partial write: address 3 holds 0x11223344; write 0xAABBCCDD with be = 4'b0101 -> read returns 0x11BB33DD.
- Streaming: 4 consecutive reads of addresses 0..3 -> 4 consecutive ovalid cycles, data in issue order. A read with cs_ = 1 -> no ovalid.
- Write to address 7 at edge N, read address 7 at edge N+1 -> new data returned. Assert rst while two reads are in flight -> no ovalid follows.
- SRAM_INIT_EN, ADDR_WIDTH = 4:
  - busy is high for exactly 16 cycles after reset release.
  - A write issued during busy is dropped.
  - After the sweep, every address reads 0.
  - Re-asserting rst at sweep cycle 8 restarts the full 16-cycle sweep.
- Without SRAM_INIT_EN: busy = 0 from reset onward, and the first access is accepted immediately.
